muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute stage; the M-extension successor to the ALU decode path. Decodes funct3 for the eight M-extension ops, computes the result over multiple cycles with a radix-2 shift-add/shift-subtract datapath, and returns it through a valid/ready handshake. Parametrised in datapath width; special divide cases resolve early.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_decode.sv | 67 ++++++
 rtl/muldiv_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // M-extension operation encodings as carried in funct3.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Widest value the sign helper handles: a 2*XLEN product for XLEN up to 64.
  localparam int MAX_W = 128;

  // Sign/magnitude conversion: two's-complement negate when neg is set.
  // Callers zero-extend into MAX_W and truncate the result back; negation
  // modulo 2^MAX_W truncates to the correct negation modulo 2^N.
  function automatic logic [MAX_W-1:0] sign_mag(input logic [MAX_W-1:0] val,
                                                input logic             neg);
    logic [MAX_W-1:0] res;
    if (neg) begin
      res = ~val + {{(MAX_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/muldiv_decode.sv
// Combinational funct3 decode into datapath control flags.
module muldiv_decode (
  input  logic [2:0] funct3,
  output logic       is_div,
  output logic       is_rem,
  output logic       a_signed,
  output logic       b_signed,
  output logic       want_high
);
  import muldiv_pkg::*;

  muldiv_op_e op_s;
  assign op_s = muldiv_op_e'(funct3);

  // Translate the operation into divide/remainder, signedness and half select.
  always_comb begin
    is_div    = 1'b0;
    is_rem    = 1'b0;
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    want_high = 1'b0;
    case (op_s)
      OP_MUL: begin
        // Low half is sign-agnostic; treat as unsigned.
        want_high = 1'b0;
      end
      OP_MULH: begin
        a_signed  = 1'b1;
        b_signed  = 1'b1;
        want_high = 1'b1;
      end
      OP_MULHSU: begin
        a_signed  = 1'b1;
        want_high = 1'b1;
      end
      OP_MULHU: begin
        want_high = 1'b1;
      end
      OP_DIV: begin
        is_div   = 1'b1;
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_DIVU: begin
        is_div = 1'b1;
      end
      OP_REM: begin
        is_div   = 1'b1;
        is_rem   = 1'b1;
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_REMU: begin
        is_div = 1'b1;
        is_rem = 1'b1;
      end
      default: begin
        is_div    = 1'b0;
        is_rem    = 1'b0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        want_high = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes.
// Operands are converted to magnitudes at accept, one bit is processed per
// CALC cycle, and the sign is restored in a single FIX cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import muldiv_pkg::*;

  localparam int              CW        = $clog2(XLEN) + 1;
  localparam int              PW        = 2 * XLEN;
  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_X    = {XLEN{1'b0}};

  // Sequencer and datapath state.
  state_e            state_r;
  state_e            state_nx;
  logic [CW-1:0]     count_r;
  logic [PW-1:0]     acc_r;
  logic [XLEN-1:0]   mcand_r;
  logic              is_div_r;
  logic              is_rem_r;
  logic              want_high_r;
  logic              neg_res_r;
  logic              neg_rem_r;
  logic [XLEN-1:0]   result_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;

  // Decode and accept-time operand preparation.
  logic              dec_div_s;
  logic              dec_rem_s;
  logic              dec_a_signed_s;
  logic              dec_b_signed_s;
  logic              dec_high_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;

  // Iteration and fix-up datapath.
  logic [XLEN:0]     mul_sum_s;
  logic [PW-1:0]     mul_step_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN-1:0]   div_rem_s;
  logic              div_qbit_s;
  logic [PW-1:0]     div_step_s;
  logic [PW-1:0]     prod_fix_s;
  logic [XLEN-1:0]   quot_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   fix_res_s;

  muldiv_decode u_decode (
    .funct3    (funct3),
    .is_div    (dec_div_s),
    .is_rem    (dec_rem_s),
    .a_signed  (dec_a_signed_s),
    .b_signed  (dec_b_signed_s),
    .want_high (dec_high_s)
  );

  assign a_neg_s    = dec_a_signed_s & src_a[XLEN-1];
  assign b_neg_s    = dec_b_signed_s & src_b[XLEN-1];
  assign mag_a_s    = XLEN'(sign_mag(MAX_W'(src_a), a_neg_s));
  assign mag_b_s    = XLEN'(sign_mag(MAX_W'(src_b), b_neg_s));
  assign div_zero_s = dec_div_s && (src_b == ZERO_X);
  assign div_ovf_s  = dec_div_s && dec_a_signed_s && (src_a == MOST_NEG) && (src_b == ALL_ONES);
  assign special_s  = div_zero_s | div_ovf_s;

  // Results for the divide cases that bypass the iterative datapath.
  always_comb begin
    special_res_s = ZERO_X;
    if (div_zero_s) begin
      special_res_s = dec_rem_s ? src_a : ALL_ONES;
    end else if (div_ovf_s) begin
      special_res_s = dec_rem_s ? ZERO_X : src_a;
    end else begin
      special_res_s = ZERO_X;
    end
  end

  // One radix-2 step: shift-add multiply and restoring shift-subtract divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[PW-1:XLEN]} +
                  (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
    mul_step_s  = {mul_sum_s, acc_r[XLEN-1:1]};
    div_shift_s = {acc_r[PW-1:XLEN], acc_r[XLEN-1]};
    div_rem_s   = div_shift_s[XLEN-1:0];
    div_qbit_s  = 1'b0;
    if (div_shift_s >= {1'b0, mcand_r}) begin
      div_rem_s  = div_shift_s[XLEN-1:0] - mcand_r;
      div_qbit_s = 1'b1;
    end else begin
      div_rem_s  = div_shift_s[XLEN-1:0];
      div_qbit_s = 1'b0;
    end
    div_step_s = {div_rem_s, acc_r[XLEN-2:0], div_qbit_s};
  end

  // Sign restoration and result selection once all iterations are complete.
  always_comb begin
    prod_fix_s = PW'(sign_mag(MAX_W'(acc_r), neg_res_r));
    quot_fix_s = XLEN'(sign_mag(MAX_W'(acc_r[XLEN-1:0]), neg_res_r));
    rem_fix_s  = XLEN'(sign_mag(MAX_W'(acc_r[PW-1:XLEN]), neg_rem_r));
    fix_res_s  = ZERO_X;
    if (is_div_r) begin
      fix_res_s = is_rem_r ? rem_fix_s : quot_fix_s;
    end else begin
      fix_res_s = want_high_r ? prod_fix_s[PW-1:XLEN] : prod_fix_s[XLEN-1:0];
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nx = state_r;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_nx = special_s ? ST_DONE : ST_CALC;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (count_r == LAST_ITER) begin
            state_nx = ST_FIX;
          end else begin
            state_nx = ST_CALC;
          end
        end
        ST_FIX: begin
          state_nx = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_DONE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx == ST_IDLE);
      out_valid_r <= (state_nx == ST_DONE);
      busy_r      <= (state_nx == ST_CALC) || (state_nx == ST_DONE);
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= {CW{1'b0}};
      acc_r       <= {PW{1'b0}};
      mcand_r     <= ZERO_X;
      is_div_r    <= 1'b0;
      is_rem_r    <= 1'b0;
      want_high_r <= 1'b0;
      neg_res_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      result_r    <= ZERO_X;
    end else if (flush) begin
      count_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            is_div_r    <= dec_div_s;
            is_rem_r    <= dec_rem_s;
            want_high_r <= dec_high_s;
            neg_res_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r   <= a_neg_s;
            mcand_r     <= mag_b_s;
            acc_r       <= {ZERO_X, mag_a_s};
            count_r     <= {CW{1'b0}};
            if (special_s) begin
              result_r <= special_res_s;
            end
          end
        end
        ST_CALC: begin
          acc_r   <= is_div_r ? div_step_s : mul_step_s;
          count_r <= count_r + CNT_ONE;
        end
        ST_FIX: begin
          result_r <= fix_res_s;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int          XLEN     = 32;
  localparam int          NORM_LAT = XLEN + 2;
  localparam int          SPEC_LAT = 1;
  localparam int          MAX_WAIT = 200;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     t;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 32'd0;
    t  = 64'd0;
    case (f)
      3'd0: begin t = ua * ub; r = t[31:0]; end
      3'd1: begin t = sa * sb; r = t[63:32]; end
      3'd2: begin t = sa * longint'(ub); r = t[63:32]; end
      3'd3: begin t = ua * ub; r = t[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = ALL_ONES;
        else if (a == MOST_NEG && b == ALL_ONES) r = a;
        else begin t = sa / sb; r = t[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? ALL_ONES : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == MOST_NEG && b == ALL_ONES) r = 32'd0;
        else begin t = sa % sb; r = t[31:0]; end
      end
      3'd7: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Present one request, scramble inputs after accept, wait for out_valid.
  // lat counts rising edges from the accept edge (inclusive) to out_valid.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    @(negedge clk);
    funct3   = f;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    funct3   = 3'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " out_valid after release"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready after release"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int          lat;
    logic [31:0] res;
    run_op(f, a, b, lat, res);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    release_result(tag);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] res;
    logic [31:0] held;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_lat;

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    funct3    = 3'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Multiply family.
    op_check("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT);
    op_check("MULH", 3'b001, MOST_NEG, ALL_ONES, 32'h0000_0000, NORM_LAT);
    op_check("MULHSU", 3'b010, MOST_NEG, ALL_ONES, 32'h8000_0000, NORM_LAT);
    op_check("MULHU", 3'b011, MOST_NEG, ALL_ONES, 32'h7FFF_FFFF, NORM_LAT);

    // Divide family.
    op_check("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM_LAT);
    op_check("REM -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORM_LAT);
    op_check("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, NORM_LAT);
    op_check("REMU 100%7", 3'b111, 32'd100, 32'd7, 32'd2, NORM_LAT);

    // Early-resolving divide cases.
    op_check("DIVU 5/0", 3'b101, 32'd5, 32'd0, ALL_ONES, SPEC_LAT);
    op_check("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5, SPEC_LAT);
    op_check("DIV 5/0", 3'b100, 32'd5, 32'd0, ALL_ONES, SPEC_LAT);
    op_check("REMU 9/0", 3'b111, 32'd9, 32'd0, 32'd9, SPEC_LAT);
    op_check("DIV ovf", 3'b100, MOST_NEG, ALL_ONES, MOST_NEG, SPEC_LAT);
    op_check("REM ovf", 3'b110, MOST_NEG, ALL_ONES, 32'd0, SPEC_LAT);
    op_check("DIVU no ovf", 3'b101, MOST_NEG, ALL_ONES, 32'd0, NORM_LAT);

    // Back-pressure in DONE; a request held meanwhile must be ignored.
    run_op(3'b101, 32'd100, 32'd7, lat, held);
    check("bp result", held, 32'd14);
    @(negedge clk);
    funct3   = 3'b000;
    src_a    = 32'd3;
    src_b    = 32'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold result", result, 32'd14);
      check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
      check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
      check("bp hold busy", {31'd0, busy}, 32'd1);
    end
    release_result("bp");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp no accept on release", {31'd0, in_ready}, 32'd1);

    // Flush during CALC iteration 10.
    @(negedge clk);
    funct3   = 3'b000;
    src_a    = 32'd123;
    src_b    = 32'd456;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush busy in CALC", {31'd0, busy}, 32'd1);
    check("flush in_ready in CALC", {31'd0, in_ready}, 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush out_valid never", 32'(seen), 32'd0);

    // Request presented together with flush in IDLE is not accepted.
    @(negedge clk);
    funct3   = 3'b101;
    src_a    = 32'd10;
    src_b    = 32'd0;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush idle in_ready", {31'd0, in_ready}, 32'd1);
    check("flush idle out_valid", {31'd0, out_valid}, 32'd0);
    check("flush idle busy", {31'd0, busy}, 32'd0);

    // Reset during CALC iteration 10.
    @(negedge clk);
    funct3   = 3'b001;
    src_a    = 32'd77;
    src_b    = 32'd99;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst result", result, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("rst out_valid never", 32'(seen), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = MOST_NEG; b = ALL_ONES; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        4: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = b;
      endcase
      exp_lat = (f[2] && (b == 32'd0 || (!f[0] && a == MOST_NEG && b == ALL_ONES)))
                ? SPEC_LAT : NORM_LAT;
      run_op(f, a, b, lat, res);
      check($sformatf("rand%0d f=%0d a=%08h b=%08h result", i, f, a, b), res, ref_model(f, a, b));
      check($sformatf("rand%0d latency", i), 32'(lat), 32'(exp_lat));
      release_result($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
